// File: rtl/mux4x1_rr_sched.sv
// Shares one byte lane between four requesters (round-robin with bursts, or fixed TDM); out is registered one cycle after the grant edge.
// ready is a one-hot grant built from state and the requests; a lane with no valid data is skipped or idled, never stalled upon.
module mux4x1_rr_sched #(
   parameter int               WIDTH    = 8,
   parameter logic [WIDTH-1:0] IDLE_SYM = WIDTH'(8'hBC),
   parameter int               BURST    = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             mode,
   input  logic [3:0]       lane_mask,
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic [WIDTH-1:0] in3,
   input  logic [3:0]       valid,
   output logic [3:0]       ready,
   output logic [WIDTH-1:0] out,
   output logic             valid_out,
   output logic [1:0]       sel
);

   typedef enum logic [1:0] {S_OFF, S_ARB, S_BURST} state_t;

   localparam logic [3:0] BURST_L = 4'(BURST);
   localparam bit         MULTI   = (BURST > 1);

   state_t           state_q, state_d;
   logic [1:0]       ptr_q, ptr_d;
   logic [3:0]       burst_cnt_q, burst_cnt_d;
   logic [1:0]       lane_q, lane_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             valid_out_q, valid_out_d;
   logic [1:0]       sel_q, sel_d;

   logic [3:0]       elig;
   logic             grant_vld;
   logic [1:0]       grant;
   logic [1:0]       idx;
   logic [WIDTH-1:0] lane_dat;

   assign elig = valid & lane_mask;

   // Grant selection: enable only gates new grants in ARB; a running burst ignores it.
   always_comb begin
      grant_vld = 1'b0;
      grant     = 2'd0;
      idx       = 2'd0;
      case (state_q)
         S_ARB: begin
            if (enable) begin
               if (mode) begin
                  grant_vld = elig[ptr_q];
                  grant     = ptr_q;
               end else begin
                  for (int k = 0; k < 4; k++) begin
                     idx = ptr_q + 2'(k);
                     if (!grant_vld && elig[idx]) begin
                        grant_vld = 1'b1;
                        grant     = idx;
                     end
                  end
               end
            end
         end
         S_BURST: begin
            grant_vld = elig[lane_q];
            grant     = lane_q;
         end
         default: ;
      endcase
   end

   assign ready = grant_vld ? (4'b0001 << grant) : 4'b0000;

   always_comb begin
      case (grant)
         2'd0:    lane_dat = in0;
         2'd1:    lane_dat = in1;
         2'd2:    lane_dat = in2;
         default: lane_dat = in3;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      burst_cnt_d = burst_cnt_q;
      lane_d      = lane_q;
      out_d       = grant_vld ? lane_dat : IDLE_SYM;
      valid_out_d = grant_vld;
      sel_d       = grant_vld ? grant : sel_q;
      case (state_q)
         S_OFF: begin
            if (enable) state_d = S_ARB;
         end
         S_ARB: begin
            if (!enable) begin
               state_d = S_OFF;
            end else if (mode) begin
               ptr_d = ptr_q + 2'd1;
            end else if (grant_vld) begin
               if (MULTI) begin
                  state_d     = S_BURST;
                  lane_d      = grant;
                  burst_cnt_d = 4'd1;
               end else begin
                  ptr_d = grant + 2'd1;
               end
            end
         end
         S_BURST: begin
            // A starved or masked lane ends its burst with an idle beat.
            if (grant_vld && (burst_cnt_q + 4'd1 != BURST_L)) begin
               burst_cnt_d = burst_cnt_q + 4'd1;
            end else begin
               state_d     = S_ARB;
               ptr_d       = lane_q + 2'd1;
               burst_cnt_d = 4'd0;
            end
         end
         default: state_d = S_OFF;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_OFF;
         ptr_q       <= 2'd0;
         burst_cnt_q <= 4'd0;
         lane_q      <= 2'd0;
         out_q       <= IDLE_SYM;
         valid_out_q <= 1'b0;
         sel_q       <= 2'd0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         burst_cnt_q <= burst_cnt_d;
         lane_q      <= lane_d;
         out_q       <= out_d;
         valid_out_q <= valid_out_d;
         sel_q       <= sel_d;
      end
   end

   assign out       = out_q;
   assign valid_out = valid_out_q;
   assign sel       = sel_q;

endmodule

// File: doc/mux4x1_rr_sched.md
Name: mux4x1_rr_sched

Overview:
- Scheduler that shares the byte-wide 4:1 lane mux between four requester lanes and emits one serialized byte stream on a single clock.
- Two modes:
  - Work-conserving round-robin: skips idle lanes, optional multi-cycle bursts.
  - Fixed TDM: lane 0→1→2→3 every cycle, same order as the existing mux4x1 datapath.
- Sits between the lane sources and the downstream byte-stripping/serializer logic of the PCIe physical layer.
- Inserts an idle symbol when no lane is served.

Parameters:
- WIDTH, 8, data width of each lane and of out.
- IDLE_SYM, 8'hBC, value driven on out when valid_out=0.
- BURST, 1, maximum consecutive transfers granted to one lane per turn (1..15).

Ports:
- clk  input  1  single scheduler clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- enable  input  1  1 = scheduling allowed; 0 = stop at next burst boundary.
- mode  input  1  0 = work-conserving round-robin, 1 = fixed TDM.
- lane_mask  input  4  bit i = 1 enables lane i.
- in0, in1, in2, in3  input  WIDTH  lane data.
- valid  input  4  bit i = lane i holds data.
- ready  output  4  bit i = lane i granted this cycle (one-hot or zero).
- out  output  WIDTH  registered output byte.
- valid_out  output  1  out carries lane data.
- sel  output  2  index of the lane that produced out.

Behaviour:
- Reset (reset=0, async):
  - state=OFF, ptr=0, burst_cnt=0.
  - out=IDLE_SYM, valid_out=0, sel=0, ready=0.
  - Reset mid-burst aborts the burst; the byte is not transferred.
- Transfer: lane i transfers on a rising edge where valid[i] & ready[i].
  - ready is combinational from state, ptr, valid, lane_mask and mode.
  - At most one bit of ready is set.
  - ready[i] never asserts when lane_mask[i]=0.
- Latency: a byte accepted at edge N appears on out with valid_out=1 and sel=i after edge N (1 cycle).
- Non-transfer cycles register out=IDLE_SYM, valid_out=0; sel holds its previous value.
- State OFF:
  - ready=0.
  - Go to ARB when enable=1, sampled on the edge.
- State ARB, mode=0:
  - Grant = first i in ptr, ptr+1, ... (mod 4) with valid[i] & lane_mask[i].
  - If a grant exists: transfer, burst_cnt=1.
    - If BURST>1 → BURST state holding lane g.
    - Else ptr=g+1 mod 4.
  - If no grant: idle cycle, ptr unchanged.
- State ARB, mode=1:
  - Candidate = ptr.
  - Grant only if valid[ptr] & lane_mask[ptr], otherwise idle cycle.
  - ptr=ptr+1 mod 4 every cycle regardless; BURST is ignored.
- State BURST, mode=0 only:
  - Stay on lane g while valid[g] & lane_mask[g] & burst_cnt<BURST; burst_cnt increments per transfer.
  - Burst ends on burst_cnt==BURST after a transfer, valid[g]=0, or lane_mask[g]=0.
    - valid[g]=0 or lane_mask[g]=0 ends it in the same cycle with no transfer and an idle output; the next edge returns to ARB.
  - On burst end: ptr=g+1 mod 4, burst_cnt=0, state→ARB.
- enable=0:
  - Sampled in ARB: go to OFF at that edge, no grant that cycle.
  - In BURST: the burst completes first, then OFF.
- mode changes take effect only in ARB; mode is ignored while in BURST.
- ptr wraps 3→0; burst_cnt is 4 bits.
- lane_mask=0 or valid=0 with enable=1 gives a continuous IDLE_SYM stream; mode=1 still rotates ptr.

Test Plan:
1. reset=0 with all valid=1 → ready=0, out=8'hBC, valid_out=0, sel=0. Release, enable=1, mode=0, BURST=1, valid=4'hF, in0..in3 = 8'h10/8'h21/8'h32/8'h43 → out sequence 10,21,32,43,10,... with sel 0,1,2,3.
2. mode=0, valid=4'b1010 → only lanes 1,3 alternate, sel=1,3,1,3, no idle gaps. Then lane_mask=4'b0111 → lane 1 only, lane 3 ready stays 0.
3. mode=1, valid=4'b0101 → out = in0, BC, in2, BC repeating; valid_out=1,0,1,0.
4. BURST=3, mode=0, valid=4'hF → three consecutive bytes from each lane with sel 0,0,0,1,1,1,... Drop valid[1] after its first byte → one idle cycle, then lane 2 is granted.
5. enable falls mid-burst (BURST=3, second beat) → third beat still transfers, then ready=0 and out=BC. Re-enable → resumes at ptr = next lane.
6. Assert reset=0 asynchronously between edges mid-burst → valid_out drops to 0 and out=BC immediately, without waiting for a clock edge. After release, first grant goes to lane 0.
